// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the receive deserializer and the i2so transmit path.
package i2s_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 6;

  // Word-select encoding on the I2S bus
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

endpackage

// File: rtl/i2si_sync.sv
// I2S input conditioning: optional 2-flop synchronizers (I2SI_SYNC_EN), sck rising-edge
// detection and ws history, producing one-cycle bit events and ws transition flags.
module i2si_sync (
  input  logic clk,
  input  logic rst,
  input  logic i2si_sck,
  input  logic i2si_ws,
  input  logic i2si_sd,
  output logic bit_evt,
  output logic ws_s,
  output logic sd_s,
  output logic ws_tog
);

  logic sck_s;
  logic sck_prev_q, sck_prev_d;
  logic ws_prev_q, ws_prev_d;

`ifdef I2SI_SYNC_EN
  logic [1:0] sck_sync_q, sck_sync_d;
  logic [1:0] ws_sync_q, ws_sync_d;
  logic [1:0] sd_sync_q, sd_sync_d;

  // Shift each external line through two stages into the clk domain
  always_comb begin
    sck_sync_d = {sck_sync_q[0], i2si_sck};
    ws_sync_d  = {ws_sync_q[0], i2si_ws};
    sd_sync_d  = {sd_sync_q[0], i2si_sd};
  end

  // Synchronizer flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q <= 2'b00;
      ws_sync_q  <= 2'b00;
      sd_sync_q  <= 2'b00;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
    end
  end

  assign sck_s = sck_sync_q[1];
  assign ws_s  = ws_sync_q[1];
  assign sd_s  = sd_sync_q[1];
`else
  assign sck_s = i2si_sck;
  assign ws_s  = i2si_ws;
  assign sd_s  = i2si_sd;
`endif

  assign bit_evt = sck_s & ~sck_prev_q;
  assign ws_tog  = bit_evt & (ws_s ^ ws_prev_q);

  // ws history only advances on bit events so a transition is seen exactly once
  always_comb begin
    sck_prev_d = sck_s;
    if (bit_evt) begin
      ws_prev_d = ws_s;
    end else begin
      ws_prev_d = ws_prev_q;
    end
  end

  // Edge-detect and ws history flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_prev_q <= 1'b0;
      ws_prev_q  <= 1'b0;
    end else begin
      sck_prev_q <= sck_prev_d;
      ws_prev_q  <= ws_prev_d;
    end
  end

endmodule

// File: rtl/i2s_in_deser.sv
// I2S receiver: deserializes left/right words into {left,right} pairs on an rts/rtr
// handshake with a sticky overrun flag. Define I2SI_SYNC_EN for asynchronous inputs.
module i2s_in_deser
  import i2s_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rf_i2si_en,
  input  logic                i2si_sck,
  input  logic                i2si_ws,
  input  logic                i2si_sd,
  output logic                i2si_rts,
  input  logic                i2si_rtr,
  output logic [2*DATA_W-1:0] i2si_data,
  input  logic                trig_i2si_fifo_overrun_clr,
  output logic                ro_fifo_overrun
);

  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic bit_evt_s, ws_s, sd_s, ws_tog_s;

  i2si_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .i2si_sck (i2si_sck),
    .i2si_ws  (i2si_ws),
    .i2si_sd  (i2si_sd),
    .bit_evt  (bit_evt_s),
    .ws_s     (ws_s),
    .sd_s     (sd_s),
    .ws_tog   (ws_tog_s)
  );

  i2s_state_e          state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   left_q, left_d;
  logic [2*DATA_W-1:0] data_q, data_d;
  logic                rts_q, rts_d;
  logic                ovr_q, ovr_d;
  logic [DATA_W-1:0]   word_s;
  logic                pair_done_s, ovr_set_s;

  // Framing FSM, bit capture and output handshake
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    data_d      = data_q;
    rts_d       = rts_q;
    pair_done_s = 1'b0;
    ovr_set_s   = 1'b0;
    // Mask falls off the end once cnt reaches DATA_W, so excess LSBs are dropped
    word_s      = sd_s ? (shreg_q | (MSB_MASK >> cnt_q)) : shreg_q;

    if (!rf_i2si_en) begin
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ws_tog_s && (ws_s == WS_LEFT)) begin
            state_d = LEFT;
            shreg_d = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        LEFT, RIGHT: begin
          if (ws_tog_s) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (state_q == LEFT) begin
              left_d  = word_s;
              state_d = RIGHT;
            end else begin
              pair_done_s = 1'b1;
              state_d     = LEFT;
            end
          end else if (bit_evt_s) begin
            shreg_d = word_s;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (pair_done_s) begin
      if (!rts_q || i2si_rtr) begin
        data_d = {left_q, word_s};
        rts_d  = 1'b1;
      end else begin
        ovr_set_s = 1'b1;
      end
    end else if (rts_q && i2si_rtr) begin
      rts_d = 1'b0;
    end else begin
      rts_d = rts_q;
    end

    if (ovr_set_s) begin
      ovr_d = 1'b1;
    end else if (trig_i2si_fifo_overrun_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      data_q  <= '0;
      rts_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      data_q  <= data_d;
      rts_q   <= rts_d;
      ovr_q   <= ovr_d;
    end
  end

  assign i2si_rts        = rts_q;
  assign i2si_data       = data_q;
  assign ro_fifo_overrun = ovr_q;

endmodule

// File: doc/i2s_in_deser.md
Name: i2s_in_deser

Overview:
I2S receive front end; the counterpart of the i2so serializer path. Samples external i2si_sck/i2si_ws/i2si_sd in the clk domain and deserializes left and right words. Presents each completed stereo pair as one {left,right} word over an rts/rtr handshake to the i2si input FIFO. Flags a sticky overrun when a new pair completes while the previous pair is still unaccepted.

Parameters:
DATA_W, 16, bits captured per channel; output word is 2*DATA_W.
CNT_W, 6, bit-counter width; frames of up to 2^CNT_W-1 sck per channel are supported.

Ports:
clk  input  1  master clock
rst  input  1  asynchronous, active-low reset
rf_i2si_en  input  1  receiver enable (register file)
i2si_sck  input  1  I2S bit clock, asynchronous to clk
i2si_ws  input  1  word select; 0 = left, 1 = right
i2si_sd  input  1  serial data, MSB first
i2si_rts  output  1  ready to send: i2si_data is valid
i2si_rtr  input  1  FIFO ready to receive
i2si_data  output  2*DATA_W  {left[DATA_W-1:0], right[DATA_W-1:0]}
trig_i2si_fifo_overrun_clr  input  1  one-clk pulse that clears overrun
ro_fifo_overrun  output  1  sticky overrun flag

Behaviour:
- Reset (rst=0, async): i2si_rts=0, i2si_data=0, ro_fifo_overrun=0, state=IDLE, shift registers and counter at 0, ws_prev=0.
- Bit event: one clk cycle when sck_s=1 and sck_d=0 (rising sck seen in the clk domain). ws and sd are sampled in that cycle only. clk must be at least 8x sck.
- WS transition: at a bit event, ws_s differs from ws_prev. Per I2S, the sd sampled in that event is the LSB of the word just ending. The next bit event carries the MSB of the new word.
- Capture: the bit counter counts bits since the word start. The first DATA_W bits shift in MSB first; bits beyond DATA_W are ignored (truncation keeps the MSBs). A word shorter than DATA_W is left-justified and zero-filled.
- FSM:
  IDLE: wait for rf_i2si_en=1 and a ws 1->0 transition, then go to LEFT; nothing is captured in IDLE.
  LEFT: ws 0->1 transition: latch left word, go to RIGHT.
  RIGHT: ws 1->0 transition: latch right word, go to LEFT, and present the pair.
  From any state, rf_i2si_en=0 returns to IDLE next clk and discards the partial frame. A held output pair is kept.
- Output: the pair is loaded into i2si_data, and i2si_rts rises, on the clk after the completing bit event.
- Transfer: occurs in a cycle with i2si_rts=1 and i2si_rtr=1; i2si_rts falls next clk. i2si_data holds its value until the next load.
- Overrun: a pair completes while i2si_rts=1 and no transfer occurs that cycle. Then the new pair is dropped, i2si_data is unchanged, and ro_fifo_overrun is set.
- A completion coinciding with a transfer loads the new pair, and i2si_rts stays 1.
- Overrun clear: trig_i2si_fifo_overrun_clr clears ro_fifo_overrun. If a set and a clear occur in the same cycle, the set wins.

Optional Feature:
I2SI_SYNC_EN defined: 2-flop synchronizers on i2si_sck, i2si_ws and i2si_sd, adding 2 clk to detection latency; reset value 0.
Not defined: inputs are used directly and must be synchronous to clk (e.g. generated on chip); the sck edge register stays.

Decomposition:
- Package i2s_pkg: DATA_W default, state typedef (IDLE, LEFT, RIGHT), frame constants shared with the i2so path.
- Sub-module i2si_sync: holds the optional synchronizers, the sck edge detector and the ws_prev register. It outputs bit_evt, ws_s, sd_s and ws_tog.

Test Plan:
- Enable, one frame with left 0xA5C3 and right 0x1234 (16 sck per channel), rtr=1 -> i2si_data=0xA5C31234, i2si_rts pulses 1 clk, overrun=0.
- Hold rtr=0 and send two frames -> data stays 0xA5C31234 and overrun=1. Clear pulse -> 0. Clear in the same cycle as a new overrun -> stays 1.
- 24-bit channels, left 0xBEEF12, right 0x0F0F00 -> data 0xBEEF0F0F. 8-bit channels 0xAB/0xCD -> 0xAB00CD00.
- Start the bitstream mid-right-word with enable=1 -> no output until after the first ws 1->0 transition. Deassert enable mid-left -> IDLE, no pair emitted, held data kept.
- Back-to-back frames with rtr tied 1 -> every pair delivered in order, no overrun. Pulse rst low mid-frame -> all outputs 0 immediately, and capture resumes only at the next ws 1->0 with enable.
